// File: rtl/tc_fetch_pkg.sv
// Shared types and sizes for the instruction-fetch front end.
package tc_fetch_pkg;

    localparam int unsigned INSTR_W         = 32;
    localparam int unsigned BYTES_PER_FETCH = 4;
    localparam int unsigned FETCH_ADDR_W    = 16;
    localparam int unsigned BUF_DEPTH       = 2;
    localparam int unsigned CNT_W           = 2;

    typedef struct packed {
        logic [INSTR_W-1:0]      instr;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/tc_fetch_buf.sv
// Two-entry instruction FIFO; head is held in registered storage, flush wins over push.
module tc_fetch_buf
    import tc_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     din,
    output fetch_entry_t     head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     head_n;
    fetch_entry_t     tail_q;
    fetch_entry_t     tail_n;
    logic [CNT_W-1:0] count_n;

    always_comb begin
        head_n  = head;
        tail_n  = tail_q;
        count_n = count;
        if (flush) begin
            count_n = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == '0) head_n = din;
                    else             tail_n = din;
                    count_n = count + CNT_W'(1);
                end
                2'b01: begin
                    head_n  = tail_q;
                    count_n = count - CNT_W'(1);
                end
                2'b11: begin
                    // Simultaneous push/pop keeps occupancy; shift when both entries live.
                    if (count == CNT_W'(1)) begin
                        head_n = din;
                    end else begin
                        head_n = tail_q;
                        tail_n = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head   <= '0;
            tail_q <= '0;
            count  <= '0;
            valid  <= 1'b0;
        end else begin
            head   <= head_n;
            tail_q <= tail_n;
            count  <= count_n;
            valid  <= (count_n != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (flush || pop || !push || (count != CNT_W'(BUF_DEPTH)));
    end

endmodule

// File: rtl/tc_fetch8_4.sv
// Instruction-fetch initiator: issues ROM reads, buffers returned words, hands them to decode.
module tc_fetch8_4
    import tc_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       STEP     = 4,
    parameter int unsigned       DEPTH    = BUF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_b0,
    input  logic [7:0]        mem_b1,
    input  logic [7:0]        mem_b2,
    input  logic [7:0]        mem_b3,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt
);

    logic [ADDR_W-1:0] pc_q, pc_n;
    logic              infl, infl_n;
    logic [ADDR_W-1:0] infl_pc, infl_pc_n;

    logic              pop;
    logic              capture;
    logic              issue;
    logic [2:0]        occ;
    logic [CNT_W-1:0]  buf_count;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    assign mem_addr = jump_en ? jump_target : pc_q;
    assign pop      = instr_valid & instr_ready;
    assign capture  = infl & ~jump_en;

    // A jump flushes everything, so the credit check sees an empty buffer.
    assign occ   = jump_en ? 3'd0 : (3'(buf_count) + 3'(capture) - 3'(pop));
    assign issue = ~halt & (occ < 3'(DEPTH));

    always_comb begin
        pc_n      = pc_q;
        infl_n    = 1'b0;
        infl_pc_n = infl_pc;
        if (issue) begin
            infl_n    = 1'b1;
            infl_pc_n = mem_addr;
            pc_n      = mem_addr + ADDR_W'(STEP);
        end else if (jump_en) begin
            pc_n = jump_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            infl    <= 1'b0;
            infl_pc <= '0;
        end else begin
            pc_q    <= pc_n;
            infl    <= infl_n;
            infl_pc <= infl_pc_n;
        end
    end

    assign push_entry.instr = {mem_b3, mem_b2, mem_b1, mem_b0};
    assign push_entry.pc    = FETCH_ADDR_W'(infl_pc);

    tc_fetch_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .pop   (pop),
        .flush (jump_en),
        .din   (push_entry),
        .head  (head),
        .valid (instr_valid),
        .count (buf_count)
    );

    assign instr    = head.instr;
    assign instr_pc = ADDR_W'(head.pc);

    always_ff @(posedge clk) begin
        if (!rst) assert (32'(buf_count) + 32'(infl) <= 32'(DEPTH));
    end

endmodule

// File: tb/tb_tc_fetch8_4.sv
// Directed bench for tc_fetch8_4: stream, stall, jump, halt, PC wrap and async reset.
module tb_tc_fetch8_4;

    logic        clk;
    logic        rst;
    logic        ready;
    logic        jump_en;
    logic [15:0] jump_target;
    logic        halt;

    logic [15:0] mem_addr, instr_pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic [7:0]  b0, b1, b2, b3;

    logic [15:0] mem_addr2, instr_pc2;
    logic [31:0] instr2;
    logic        instr_valid2;
    logic [7:0]  c0, c1, c2, c3;

    int n_tests = 0;
    int n_fail  = 0;

    tc_fetch8_4 dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr),
        .mem_b0(b0), .mem_b1(b1), .mem_b2(b2), .mem_b3(b3),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(ready), .jump_en(jump_en), .jump_target(jump_target), .halt(halt)
    );

    tc_fetch8_4 #(.RESET_PC(16'hFFF8)) dut2 (
        .clk(clk), .rst(rst), .mem_addr(mem_addr2),
        .mem_b0(c0), .mem_b1(c1), .mem_b2(c2), .mem_b3(c3),
        .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2),
        .instr_ready(1'b1), .jump_en(1'b0), .jump_target(16'h0000), .halt(1'b0)
    );

    // ROM model: each byte equals the low byte of its address, 1-cycle registered read.
    always @(posedge clk) begin
        b0 <= 8'(mem_addr);
        b1 <= 8'(mem_addr + 16'd1);
        b2 <= 8'(mem_addr + 16'd2);
        b3 <= 8'(mem_addr + 16'd3);
        c0 <= 8'(mem_addr2);
        c1 <= 8'(mem_addr2 + 16'd1);
        c2 <= 8'(mem_addr2 + 16'd2);
        c3 <= 8'(mem_addr2 + 16'd3);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ready = 1'b1; jump_en = 1'b0; jump_target = '0; halt = 1'b0;

        step();
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_pc", 64'(instr_pc), 64'd0);
        rst = 1'b0;

        // Stream from reset
        step();
        check("c1_valid", 64'(instr_valid), 64'd0);
        step();
        check("c2_valid", 64'(instr_valid), 64'd1);
        check("c2_pc", 64'(instr_pc), 64'h0000);
        check("c2_instr", 64'(instr), 64'h03020100);
        check("w2_pc", 64'(instr_pc2), 64'hFFF8);
        check("w2_instr", 64'(instr2), 64'hFBFAF9F8);
        step();
        check("c3_pc", 64'(instr_pc), 64'h0004);
        check("c3_instr", 64'(instr), 64'h07060504);
        check("w3_pc", 64'(instr_pc2), 64'hFFFC);
        step();
        check("c4_pc", 64'(instr_pc), 64'h0008);
        check("w4_pc", 64'(instr_pc2), 64'h0000);
        check("w4_instr", 64'(instr2), 64'h03020100);
        step();
        check("c5_pc", 64'(instr_pc), 64'h000C);
        check("w5_pc", 64'(instr_pc2), 64'h0004);

        // Backpressure
        ready = 1'b0;
        for (int i = 6; i <= 8; i++) begin
            step();
            check("stall_valid", 64'(instr_valid), 64'd1);
            check("stall_pc", 64'(instr_pc), 64'h000C);
            check("stall_instr", 64'(instr), 64'h0F0E0D0C);
            check("stall_addr", 64'(mem_addr), 64'h0014);
        end
        check("stall_count", 64'(dut.buf_count), 64'd2);
        check("stall_infl", 64'(dut.infl), 64'd0);
        ready = 1'b1;
        step();
        check("c9_pc", 64'(instr_pc), 64'h0010);
        step();
        check("c10_pc", 64'(instr_pc), 64'h0014);
        step();
        check("c11_pc", 64'(instr_pc), 64'h0018);
        check("c11_valid", 64'(instr_valid), 64'd1);

        // Jump while the head is being popped
        jump_en = 1'b1; jump_target = 16'h0101;
        #1;
        check("jump_addr", 64'(mem_addr), 64'h0101);
        step();
        jump_en = 1'b0;
        check("j1_valid", 64'(instr_valid), 64'd0);
        step();
        check("j2_valid", 64'(instr_valid), 64'd1);
        check("j2_pc", 64'(instr_pc), 64'h0101);
        check("j2_instr", 64'(instr), 64'h04030201);
        step();
        check("j3_pc", 64'(instr_pc), 64'h0105);
        check("j3_instr", 64'(instr), 64'h08070605);

        // Halt: buffered and in-flight words drain, then nothing
        halt = 1'b1;
        step();
        check("h1_pc", 64'(instr_pc), 64'h0109);
        check("h1_valid", 64'(instr_valid), 64'd1);
        step();
        check("h2_valid", 64'(instr_valid), 64'd0);
        step();
        check("h3_valid", 64'(instr_valid), 64'd0);
        check("h3_infl", 64'(dut.infl), 64'd0);
        check("h3_addr", 64'(mem_addr), 64'h010D);
        halt = 1'b0;
        step();
        check("r1_valid", 64'(instr_valid), 64'd0);
        step();
        check("r2_pc", 64'(instr_pc), 64'h010D);
        check("r2_instr", 64'(instr), 64'h100F0E0D);

        // Fill the buffer, then async reset mid-cycle
        ready = 1'b0;
        step();
        check("full_count", 64'(dut.buf_count), 64'd2);
        check("full_pc", 64'(instr_pc), 64'h010D);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(instr_valid), 64'd0);
        check("arst_instr", 64'(instr), 64'd0);
        check("arst_count", 64'(dut.buf_count), 64'd0);
        step();
        rst = 1'b0; ready = 1'b1;
        step();
        check("rr1_valid", 64'(instr_valid), 64'd0);
        step();
        check("rr2_valid", 64'(instr_valid), 64'd1);
        check("rr2_pc", 64'(instr_pc), 64'h0000);
        check("rr2_instr", 64'(instr), 64'h03020100);
        step();
        check("rr3_pc", 64'(instr_pc), 64'h0004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
